// File: rtl/md_cart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package : md_cart_pkg
// Brief   : Shared types and constants for the cartridge bridge.
// Rev     : 1.0  initial release
// ============================================================================
package md_cart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int         SLOT_W     = 3;
    localparam int         SLOT_OFS_W = 18;
    localparam logic [3:0] REG_BASE   = 4'hF;

endpackage
`default_nettype wire

// File: rtl/md_cart_bankregs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : md_cart_bankregs
// Brief  : SSF2-style bank registers, write decode and address translation.
// Rev    : 1.0  initial release
// ============================================================================
module md_cart_bankregs
    import md_cart_pkg::*;
#(
    parameter int BANK_BITS = 6,
    parameter int NUM_SLOTS = 8,
    localparam int MEM_AW   = BANK_BITS + SLOT_OFS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [22:0]       i_va,
    input  logic [15:0]       i_vd,
    input  logic              i_lwr,
    input  logic              i_time,
    output logic              o_map_en,
    output logic              o_wr,
    output logic [MEM_AW-1:0] o_xlat_addr
);

    logic                 r_lwr;
    logic                 r_lwr_d;
    logic                 r_map_en;
    logic [BANK_BITS-1:0] r_bank    [NUM_SLOTS];
    logic [BANK_BITS-1:0] w_bank_nx [NUM_SLOTS];
    logic                 w_map_en_nx;
    logic                 w_wr;
    logic [2:0]           w_idx;
    logic [SLOT_W-1:0]    w_slot;
    logic [BANK_BITS-1:0] w_eff_bank;
    logic                 w_unused;

    assign w_wr     = r_lwr_d & ~r_lwr & ~i_time & (i_va[7:4] == REG_BASE);
    assign w_idx    = i_va[3:1];
    assign w_slot   = i_va[20:18];
    assign w_unused = &{1'b0, i_va[22:21], i_va[0], i_vd};

    // Next-state view of the registers; translation reads it so a write in
    // the same cycle as an access start is already visible.
    always_comb begin
        w_map_en_nx = r_map_en;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_bank_nx[i] = r_bank[i];
        end
        if (w_wr) begin
            if (w_idx == 3'd0) begin
                w_map_en_nx = i_vd[0];
            end else begin
                w_bank_nx[w_idx] = i_vd[BANK_BITS-1:0];
            end
        end
        w_bank_nx[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lwr    <= 1'b1;
            r_lwr_d  <= 1'b1;
            r_map_en <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_bank[i] <= BANK_BITS'(i);
            end
        end else begin
            r_lwr    <= i_lwr;
            r_lwr_d  <= r_lwr;
            r_map_en <= w_map_en_nx;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_bank[i] <= w_bank_nx[i];
            end
        end
    end

    assign w_eff_bank  = w_map_en_nx ? w_bank_nx[w_slot]
                                     : {{(BANK_BITS-SLOT_W){1'b0}}, w_slot};
    assign o_xlat_addr = {w_eff_bank, i_va[SLOT_OFS_W-1:0]};
    assign o_map_en    = r_map_en;
    assign o_wr        = w_wr;

endmodule
`default_nettype wire

// File: rtl/md_cart_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : md_cart_bridge
// Brief  : Cart strobe to req/ack ROM fetch bridge with bank mapper,
//          one-entry read cache and latency watchdog.
// Rev    : 1.0  initial release
// ============================================================================
module md_cart_bridge
    import md_cart_pkg::*;
#(
    parameter int BANK_BITS = 6,
    parameter int NUM_SLOTS = 8,
    parameter int MAX_LAT   = 12,
    parameter int CACHE_EN  = 1,
    localparam int MEM_AW   = BANK_BITS + SLOT_OFS_W
) (
    input  logic              MCLK,
    input  logic              ext_reset,
    input  logic [22:0]       VA,
    input  logic [15:0]       VD_i,
    input  logic              CAS0,
    input  logic              CE0,
    input  logic              LWR,
    input  logic              TIME,
    output logic [15:0]       cart_data,
    output logic              cart_valid,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              map_en,
    output logic              late_sticky,
    output logic [7:0]        late_cnt
);

    localparam int            WD_W   = $clog2(MAX_LAT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_LAT);

    state_t              r_state, w_state_nx;
    logic                r_rd_n, r_rd_n_d;
    logic                r_mem_req, w_req_nx;
    logic [MEM_AW-1:0]   r_mem_addr, w_addr_nx;
    logic [15:0]         r_cart_data, w_data_nx;
    logic                r_cart_valid, w_valid_nx;
    logic [MEM_AW-1:0]   r_c_addr, w_c_addr_nx;
    logic [15:0]         r_c_data, w_c_data_nx;
    logic                r_c_valid, w_c_valid_nx;
    logic [WD_W-1:0]     r_wd_cnt, w_wd_nx;
    logic                w_late;
    logic                r_late_sticky;
    logic [7:0]          r_late_cnt;
    logic                w_start;
    logic                w_hit;
    logic                w_wr;
    logic [MEM_AW-1:0]   w_xlat_addr;

    md_cart_bankregs #(
        .BANK_BITS (BANK_BITS),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_bankregs (
        .clk         (MCLK),
        .rst         (ext_reset),
        .i_va        (VA),
        .i_vd        (VD_i),
        .i_lwr       (LWR),
        .i_time      (TIME),
        .o_map_en    (map_en),
        .o_wr        (w_wr),
        .o_xlat_addr (w_xlat_addr)
    );

    assign w_start = r_rd_n_d & ~r_rd_n;
    // A write in the same cycle invalidates before the lookup.
    assign w_hit   = (CACHE_EN != 0) && r_c_valid && !w_wr && (w_xlat_addr == r_c_addr);

    always_comb begin
        w_state_nx   = r_state;
        w_req_nx     = r_mem_req;
        w_addr_nx    = r_mem_addr;
        w_data_nx    = r_cart_data;
        w_valid_nx   = r_cart_valid;
        w_c_addr_nx  = r_c_addr;
        w_c_data_nx  = r_c_data;
        w_c_valid_nx = r_c_valid;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_addr_nx = w_xlat_addr;
                    if (w_hit) begin
                        w_state_nx = HOLD;
                        w_valid_nx = 1'b1;
                        w_data_nx  = r_c_data;
                    end else begin
                        w_state_nx = FETCH;
                        w_req_nx   = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    w_req_nx     = 1'b0;
                    w_data_nx    = mem_rdata;
                    w_valid_nx   = 1'b1;
                    w_c_addr_nx  = r_mem_addr;
                    w_c_data_nx  = mem_rdata;
                    w_c_valid_nx = 1'b1;
                    w_state_nx   = HOLD;
                end else if (r_rd_n) begin
                    w_state_nx = DRAIN;
                end
            end
            DRAIN: begin
                // The CPU has moved on; keep the word for a likely re-read.
                if (mem_ack) begin
                    w_req_nx     = 1'b0;
                    w_c_addr_nx  = r_mem_addr;
                    w_c_data_nx  = mem_rdata;
                    w_c_valid_nx = 1'b1;
                    w_state_nx   = IDLE;
                end
            end
            HOLD: begin
                if (r_rd_n) begin
                    w_valid_nx = 1'b0;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
        if (w_wr) begin
            w_c_valid_nx = 1'b0;
        end
    end

    // Counter parks at MAX_LAT, so the late event fires once per fetch.
    always_comb begin
        w_wd_nx = '0;
        w_late  = 1'b0;
        if (r_mem_req) begin
            if (r_wd_cnt != WD_MAX) begin
                w_wd_nx = r_wd_cnt + 1'b1;
                w_late  = (w_wd_nx == WD_MAX) && !mem_ack;
            end else begin
                w_wd_nx = r_wd_cnt;
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (ext_reset) begin
            r_state       <= IDLE;
            r_rd_n        <= 1'b1;
            r_rd_n_d      <= 1'b1;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_cart_data   <= '0;
            r_cart_valid  <= 1'b0;
            r_c_addr      <= '0;
            r_c_data      <= '0;
            r_c_valid     <= 1'b0;
            r_wd_cnt      <= '0;
            r_late_sticky <= 1'b0;
            r_late_cnt    <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_rd_n        <= CAS0 | CE0;
            r_rd_n_d      <= r_rd_n;
            r_mem_req     <= w_req_nx;
            r_mem_addr    <= w_addr_nx;
            r_cart_data   <= w_data_nx;
            r_cart_valid  <= w_valid_nx;
            r_c_addr      <= w_c_addr_nx;
            r_c_data      <= w_c_data_nx;
            r_c_valid     <= w_c_valid_nx;
            r_wd_cnt      <= w_wd_nx;
            if (w_late) begin
                r_late_sticky <= 1'b1;
                if (r_late_cnt != 8'hFF) begin
                    r_late_cnt <= r_late_cnt + 8'd1;
                end
            end
        end
    end

    assign cart_data   = r_cart_data;
    assign cart_valid  = r_cart_valid;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign late_sticky = r_late_sticky;
    assign late_cnt    = r_late_cnt;

endmodule
`default_nettype wire
